sd_sector_reader: RTL and testbench
===================================

// Module: sd_sector_reader
// PURPOSE
//  Autonomous SD single-block read engine, downstream of the SPI byte engine.
//  After CMD17 is sent it clocks 0xFF bytes to hunt for the start token, then captures the 512 data bytes.
//  It discards the 2 CRC bytes and packs the data big-endian into a 16-bit word FIFO that the 68K side pops.
//  Backpressure: a byte exchange is issued only when the FIFO has room.
// PARAMETERS
//  DEPTH_LOG2    8     FIFO depth = 2**DEPTH_LOG2 words (256 words = one sector)
//  SECTOR_BYTES  512   data bytes per block (must be even)
//  HUNT_MAX      1023  max 0xFF exchanges while waiting for token before TIMEOUT
// PORTS
//  CLOCK_50      in   1   system clock, all logic on rising edge
//  nRESET        in   1   synchronous, active-low reset
//  START         in   1   1-cycle pulse: flush FIFO, begin token hunt
//  ABORT         in   1   1-cycle pulse: stop, flush FIFO, go IDLE
//  SPI_START     out  1   1-cycle pulse: SPI engine sends 0xFF and receives one byte
//  SPI_RX_VALID  in   1   1-cycle pulse: SPI_RX holds the byte from the last exchange
//  SPI_RX        in   8   received byte
//  RD_POP        in   1   1-cycle pulse: consume head word
//  RD_DATA       out  16  head word (valid when !EMPTY)
//  WORDS         out  DEPTH_LOG2+1  words currently in FIFO
//  EMPTY         out  1   WORDS==0
//  FULL          out  1   WORDS==2**DEPTH_LOG2
//  ACTIVE        out  1   state != IDLE
//  DONE          out  1   sticky: block completed OK; cleared by START/ABORT
//  ERROR         out  2   sticky: 00 none, 01 timeout, 10 data-error token; cleared by START/ABORT
// BEHAVIOUR
//  Reset: state IDLE, FIFO flushed, SPI_START=0, RD_DATA=0, WORDS=0, EMPTY=1, FULL=0, ACTIVE=0, DONE=0, ERROR=00.
//  States: IDLE, HUNT_ISSUE, HUNT_WAIT, DATA_ISSUE, DATA_WAIT, CRC_ISSUE, CRC_WAIT.
//  - IDLE: on START -> HUNT_ISSUE; hunt counter=0, byte counter=0, FIFO flushed, DONE/ERROR cleared.
//  - HUNT_ISSUE: pulse SPI_START for exactly 1 cycle, hunt counter++, -> HUNT_WAIT.
//  - HUNT_WAIT on SPI_RX_VALID:
//    - 0xFE -> DATA_ISSUE.
//    - 0xFF and hunt counter < HUNT_MAX -> HUNT_ISSUE.
//    - 0xFF and hunt counter == HUNT_MAX -> ERROR=01, IDLE.
//    - upper nibble 0000 -> ERROR=10, IDLE.
//    - any other byte is treated as 0xFF.
//  - DATA_ISSUE: waits until a word slot is free. Condition: WORDS<DEPTH, or WORDS==DEPTH with RD_POP this cycle.
//    Then pulse SPI_START, -> DATA_WAIT.
//  - DATA_WAIT on SPI_RX_VALID:
//    - even byte index: latch into high-byte holding register.
//    - odd byte index: push {hold,SPI_RX} into FIFO.
//    - byte counter++; at SECTOR_BYTES -> CRC_ISSUE, else DATA_ISSUE.
//  - CRC_ISSUE/CRC_WAIT: two exchanges, bytes discarded, no backpressure. Then DONE=1, -> IDLE.
//  - SPI_START never asserts while waiting for SPI_RX_VALID (at most one exchange in flight).
//  - SPI_RX_VALID outside *_WAIT states is ignored.
//  - Latency: SPI_START is asserted 1 cycle after entering an *_ISSUE state with its condition true.
//  - FIFO is show-ahead: RD_DATA presents the head word.
//    - After a push into an empty FIFO, EMPTY=0 and RD_DATA valid on the next cycle.
//    - After a pop, the next head appears on the next cycle.
//  - Pointers wrap modulo 2**DEPTH_LOG2; WORDS is full width, so full and empty are distinct.
//  - Simultaneous push and pop: WORDS unchanged, both take effect, including when FULL or when WORDS==1.
//  - RD_POP when EMPTY: ignored; WORDS, pointers and RD_DATA unchanged.
//  - START while ACTIVE: ignored. ABORT has priority over START and all state transitions, in any state.
//  - ABORT: flushes FIFO and the holding register, clears DONE/ERROR, -> IDLE. A pending SPI_RX_VALID is then ignored.
//  - nRESET low mid-block: same as reset values, regardless of SPI engine state.
// TESTING
//  1. START; model returns FF,FF,FE then bytes 00..FF,00..FF, CRC AA,55 -> FIFO 256 words.
//     First word 0x0001, last 0xFEFF, DONE=1, ERROR=00, exactly 517 SPI_START pulses.
//  2. START; model returns 0xFF forever -> ERROR=01 after exactly HUNT_MAX(1023) SPI_START pulses.
//     ACTIVE=0, FIFO empty.
//  3. START; model returns FF,0x08 -> ERROR=10 after 2 SPI_START pulses, DONE=0.
//  4. DEPTH_LOG2=4, no pops -> SPI_START stalls with WORDS=16, FULL=1.
//     Popping one word issues the next 2 exchanges. Full drain yields the correct 256 ordered words.
//  5. Pop on the same cycle as a push with WORDS=1 -> WORDS stays 1, RD_DATA becomes the new word.
//     RD_POP while EMPTY -> no change.
//  6. ABORT after 100 data bytes -> IDLE next cycle, WORDS=0, DONE=0.
//     A late SPI_RX_VALID is ignored. A new START reads a full correct block.

Source files
------------

// File: rtl/sd_sector_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sd_sector_reader: SD single-block read engine feeding a 16-bit word FIFO. |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module sd_sector_reader #(
  parameter int DEPTH_LOG2   = 8,
  parameter int SECTOR_BYTES = 512,
  parameter int HUNT_MAX     = 1023
) (
  input  logic                  CLOCK_50,
  input  logic                  nRESET,
  input  logic                  START,
  input  logic                  ABORT,
  output logic                  SPI_START,
  input  logic                  SPI_RX_VALID,
  input  logic [7:0]            SPI_RX,
  input  logic                  RD_POP,
  output logic [15:0]           RD_DATA,
  output logic [DEPTH_LOG2:0]   WORDS,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ACTIVE,
  output logic                  DONE,
  output logic [1:0]            ERROR
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int BCW     = $clog2(SECTOR_BYTES + 1);
  localparam int HCW     = $clog2(HUNT_MAX + 1);
  localparam int SB_LAST = SECTOR_BYTES - 1;

  localparam logic [DEPTH_LOG2:0]   C_DEPTH     = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE   = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [HCW-1:0]        C_HUNT_LAST = HUNT_MAX[HCW-1:0];
  localparam logic [HCW-1:0]        C_HUNT_ONE  = {{(HCW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0]        C_BYTE_LAST = SB_LAST[BCW-1:0];
  localparam logic [BCW-1:0]        C_BYTE_ONE  = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [1:0]            C_ERR_NONE  = 2'b00;
  localparam logic [1:0]            C_ERR_TMO   = 2'b01;
  localparam logic [1:0]            C_ERR_TOKEN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_HUNT_ISSUE = 3'd1,
    S_HUNT_WAIT  = 3'd2,
    S_DATA_ISSUE = 3'd3,
    S_DATA_WAIT  = 3'd4,
    S_CRC_ISSUE  = 3'd5,
    S_CRC_WAIT   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic                  spi_start_q, spi_start_d;
  logic [HCW-1:0]        hunt_cnt_q, hunt_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]            hold_q, hold_d;
  logic                  crc_cnt_q, crc_cnt_d;
  logic                  done_q, done_d;
  logic [1:0]            error_q, error_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [15:0]           mem_q [DEPTH];

  logic w_push;
  logic w_pop;
  logic w_flush;

  always_comb begin
    state_d     = state_q;
    spi_start_d = 1'b0;
    hunt_cnt_d  = hunt_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    hold_d      = hold_q;
    crc_cnt_d   = crc_cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    w_pop       = RD_POP && (count_q != '0);

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d    = S_HUNT_ISSUE;
          hunt_cnt_d = '0;
          byte_cnt_d = '0;
          crc_cnt_d  = 1'b0;
          done_d     = 1'b0;
          error_d    = C_ERR_NONE;
          w_flush    = 1'b1;
        end
      end
      S_HUNT_ISSUE: begin
        spi_start_d = 1'b1;
        hunt_cnt_d  = hunt_cnt_q + C_HUNT_ONE;
        state_d     = S_HUNT_WAIT;
      end
      S_HUNT_WAIT: begin
        if (SPI_RX_VALID) begin
          if (SPI_RX == 8'hFE) begin
            state_d = S_DATA_ISSUE;
          end else if (SPI_RX[7:4] == 4'h0) begin
            error_d = C_ERR_TOKEN;
            state_d = S_IDLE;
          end else if (hunt_cnt_q == C_HUNT_LAST) begin
            error_d = C_ERR_TMO;
            state_d = S_IDLE;
          end else begin
            state_d = S_HUNT_ISSUE;
          end
        end
      end
      S_DATA_ISSUE: begin
        // A pop on a full FIFO frees the slot in time for the eventual push.
        if ((count_q != C_DEPTH) || RD_POP) begin
          spi_start_d = 1'b1;
          state_d     = S_DATA_WAIT;
        end
      end
      S_DATA_WAIT: begin
        if (SPI_RX_VALID) begin
          if (!byte_cnt_q[0]) begin
            hold_d = SPI_RX;
          end else begin
            w_push = 1'b1;
          end
          byte_cnt_d = byte_cnt_q + C_BYTE_ONE;
          state_d    = (byte_cnt_q == C_BYTE_LAST) ? S_CRC_ISSUE : S_DATA_ISSUE;
        end
      end
      S_CRC_ISSUE: begin
        spi_start_d = 1'b1;
        state_d     = S_CRC_WAIT;
      end
      S_CRC_WAIT: begin
        if (SPI_RX_VALID) begin
          if (crc_cnt_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            crc_cnt_d = 1'b1;
            state_d   = S_CRC_ISSUE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ABORT) begin
      state_d     = S_IDLE;
      spi_start_d = 1'b0;
      hold_d      = 8'h00;
      done_d      = 1'b0;
      error_d     = C_ERR_NONE;
      w_push      = 1'b0;
      w_flush     = 1'b1;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + C_PTR_ONE;
      if (w_pop)  rd_ptr_d = rd_ptr_q + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + C_CNT_ONE;
        2'b01:   count_d = count_q - C_CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      spi_start_q <= 1'b0;
      hunt_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      hold_q      <= 8'h00;
      crc_cnt_q   <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= C_ERR_NONE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      spi_start_q <= spi_start_d;
      hunt_cnt_q  <= hunt_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      hold_q      <= hold_d;
      crc_cnt_q   <= crc_cnt_d;
      done_q      <= done_d;
      error_q     <= error_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage carries no reset; RD_DATA is forced to zero while the FIFO is empty.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) mem_q[wr_ptr_q] <= {hold_q, SPI_RX};
  end

  assign SPI_START = spi_start_q;
  assign RD_DATA   = (count_q == '0) ? 16'h0000 : mem_q[rd_ptr_q];
  assign WORDS     = count_q;
  assign EMPTY     = (count_q == '0);
  assign FULL      = (count_q == C_DEPTH);
  assign ACTIVE    = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign ERROR     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_sector_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sd_sector_reader: directed bench with SPI responder and FIFO model.   |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
module tb_sd_sector_reader;

  localparam int N        = 2;
  localparam int HUNT_MAX = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       start, abort_s, rd_pop, spi_rx_valid;
  logic [N-1:0][7:0]  spi_rx;
  logic [N-1:0]       spi_start, empty, full, active, done;
  logic [N-1:0][15:0] rd_data;
  logic [N-1:0][8:0]  words;
  logic [N-1:0][1:0]  dut_err;

  // Responder state: ridx = next exchange index, pidx/vidx = pending/delivered index
  int rmode [N];
  int ridx [N];
  int pidx [N];
  int vidx [N];
  int rpend [N];
  int npulse [N];

  // Model: words pushed/popped since START, plus status flags
  int         mpush [N];
  int         mpop [N];
  bit         mact [N];
  bit         mdone [N];
  logic [1:0] merr [N];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  function automatic logic [7:0] resp(input int mode, input int k);
    if (mode == 1) return 8'hFF;
    if (mode == 2) return (k == 1) ? 8'h08 : 8'hFF;
    if (k < 2)    return 8'hFF;
    if (k == 2)   return 8'hFE;
    if (k <= 514) return 8'(k - 3);
    if (k == 515) return 8'hAA;
    if (k == 516) return 8'h55;
    return 8'hFF;
  endfunction

  function automatic logic [15:0] wordf(input int j);
    logic [7:0] a, b;
    a = 8'(2 * j);
    b = 8'(2 * j + 1);
    return {a, b};
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got 0x%0h want 0x%0h", nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int DL = (g == 0) ? 8 : 4;
    logic [DL:0] w_words;

    sd_sector_reader #(.DEPTH_LOG2(DL), .SECTOR_BYTES(512), .HUNT_MAX(HUNT_MAX)) u_dut (
      .CLOCK_50    (clk),
      .nRESET      (rst_n),
      .START       (start[g]),
      .ABORT       (abort_s[g]),
      .SPI_START   (spi_start[g]),
      .SPI_RX_VALID(spi_rx_valid[g]),
      .SPI_RX      (spi_rx[g]),
      .RD_POP      (rd_pop[g]),
      .RD_DATA     (rd_data[g]),
      .WORDS       (w_words),
      .EMPTY       (empty[g]),
      .FULL        (full[g]),
      .ACTIVE      (active[g]),
      .DONE        (done[g]),
      .ERROR       (dut_err[g])
    );
    assign words[g] = 9'(w_words);

    initial begin
      spi_rx_valid[g] = 1'b0;
      spi_rx[g]       = 8'h00;
      forever begin
        @(negedge clk);
        if (spi_start[g] === 1'b1) chk("one_in_flight", g, rpend[g], 0);
        spi_rx_valid[g] = 1'b0;
        if (rpend[g] > 0) begin
          rpend[g]--;
          if (rpend[g] == 0) begin
            spi_rx_valid[g] = 1'b1;
            spi_rx[g]       = resp(rmode[g], pidx[g]);
            vidx[g]         = pidx[g];
          end
        end
        if (spi_start[g] === 1'b1) begin
          pidx[g] = ridx[g];
          ridx[g]++;
          npulse[g]++;
          rpend[g] = 1 + (ridx[g] % 3);
        end
      end
    end
  end

  always @(posedge clk) begin
    bit popok;
    int k;
    for (int g = 0; g < N; g++) begin
      if (!rst_n || abort_s[g]) begin
        mpush[g] <= 0; mpop[g] <= 0; mact[g] <= 1'b0; mdone[g] <= 1'b0; merr[g] <= 2'b00;
      end else if (start[g] && !mact[g]) begin
        mpush[g] <= 0; mpop[g] <= 0; mact[g] <= 1'b1; mdone[g] <= 1'b0; merr[g] <= 2'b00;
      end else begin
        popok = rd_pop[g] && (mpush[g] > mpop[g]);
        if (spi_rx_valid[g] && mact[g]) begin
          k = vidx[g];
          if (rmode[g] == 0) begin
            if (k >= 3 && k <= 514 && ((k - 3) % 2) == 1) mpush[g] <= mpush[g] + 1;
            else if (k == 516) begin mdone[g] <= 1'b1; mact[g] <= 1'b0; end
          end else if (rmode[g] == 1) begin
            if (k == HUNT_MAX - 1) begin merr[g] <= 2'b01; mact[g] <= 1'b0; end
          end else begin
            if (k == 1) begin merr[g] <= 2'b10; mact[g] <= 1'b0; end
          end
        end
        if (popok) mpop[g] <= mpop[g] + 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        for (int g = 0; g < N; g++) begin
          chk("m_words",  g, {23'd0, words[g]}, mpush[g] - mpop[g]);
          chk("m_empty",  g, {31'd0, empty[g]}, {31'd0, mpush[g] == mpop[g]});
          chk("m_full",   g, {31'd0, full[g]},  {31'd0, (mpush[g] - mpop[g]) == ((g == 0) ? 256 : 16)});
          chk("m_active", g, {31'd0, active[g]}, {31'd0, mact[g]});
          chk("m_done",   g, {31'd0, done[g]},   {31'd0, mdone[g]});
          chk("m_error",  g, {30'd0, dut_err[g]}, {30'd0, merr[g]});
          if (mpush[g] > mpop[g]) chk("m_head", g, {16'd0, rd_data[g]}, {16'd0, wordf(mpop[g])});
        end
      end
    end
  end

  task automatic chk_reset(input int g);
    chk("rst_spi_start", g, {31'd0, spi_start[g]}, 0);
    chk("rst_rd_data",   g, {16'd0, rd_data[g]}, 0);
    chk("rst_words",     g, {23'd0, words[g]}, 0);
    chk("rst_empty",     g, {31'd0, empty[g]}, 1);
    chk("rst_full",      g, {31'd0, full[g]}, 0);
    chk("rst_active",    g, {31'd0, active[g]}, 0);
    chk("rst_done",      g, {31'd0, done[g]}, 0);
    chk("rst_error",     g, {30'd0, dut_err[g]}, 0);
  endtask

  task automatic do_start(input int g, input int mode);
    @(negedge clk); #2;
    rmode[g] = mode; ridx[g] = 0; npulse[g] = 0; start[g] = 1'b1;
    @(negedge clk); #2;
    start[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget, input string nm);
    int n = 0;
    while (active[g] !== 1'b0 && n < budget) begin
      @(negedge clk); #2; n++;
    end
    chk(nm, g, {31'd0, active[g]}, 0);
  endtask

  task automatic drain(input int g, input int j0, input int nwords, input int budget, input string nm);
    int j = j0;
    int n = 0;
    while (j < j0 + nwords && n < budget) begin
      @(negedge clk); #2;
      if (empty[g] == 1'b0) begin
        chk(nm, g, {16'd0, rd_data[g]}, {16'd0, wordf(j)});
        rd_pop[g] = 1'b1;
        j++;
      end else begin
        rd_pop[g] = 1'b0;
      end
      n++;
    end
    @(negedge clk); #2;
    rd_pop[g] = 1'b0;
    chk({nm, "_count"}, g, j, j0 + nwords);
  endtask

  task automatic test_pop_push();
    int n = 0;
    int coin = 0;
    bit pend = 1'b0;
    logic [15:0] expw = 16'h0000;
    do_start(0, 0);
    while ((active[0] !== 1'b0 || pend) && n < 6000) begin
      @(negedge clk); #2; n++;
      if (pend) begin
        chk("t5_words", 0, {23'd0, words[0]}, 1);
        chk("t5_head",  0, {16'd0, rd_data[0]}, {16'd0, expw});
        pend = 1'b0;
      end
      if (words[0] > 9'd1) begin
        rd_pop[0] = 1'b1;
      end else if (words[0] == 9'd1 && spi_rx_valid[0] && vidx[0] >= 4 && vidx[0] <= 514 &&
                   ((vidx[0] - 3) % 2) == 1) begin
        rd_pop[0] = 1'b1;
        expw = wordf((vidx[0] - 4) / 2);
        coin++;
        pend = 1'b1;
      end else begin
        rd_pop[0] = 1'b0;
      end
    end
    rd_pop[0] = 1'b0;
    chk("t5_idle", 0, {31'd0, active[0]}, 0);
    chk("t5_coincide", 0, coin, 255);
    @(negedge clk); #2;
    chk("t5_last_words", 0, {23'd0, words[0]}, 1);
    chk("t5_last_head", 0, {16'd0, rd_data[0]}, 16'hFEFF);
    rd_pop[0] = 1'b1;
    @(negedge clk); #2;
    chk("t5_drained", 0, {23'd0, words[0]}, 0);
    @(negedge clk); #2;
    rd_pop[0] = 1'b0;
    chk("t5_pop_empty_words", 0, {23'd0, words[0]}, 0);
    chk("t5_pop_empty_flag",  0, {31'd0, empty[0]}, 1);
  endtask

  task automatic test_abort();
    int n = 0;
    do_start(0, 0);
    while (!(spi_rx_valid[0] === 1'b1 && vidx[0] == 102) && n < 2000) begin
      @(negedge clk); #2; n++;
    end
    chk("t6_reach_byte100", 0, {31'd0, spi_rx_valid[0]}, 1);
    n = 0;
    while (spi_start[0] !== 1'b1 && n < 50) begin
      @(negedge clk); #2; n++;
    end
    chk("t6_next_issue", 0, {31'd0, spi_start[0]}, 1);
    chk("t6_words_before", 0, {23'd0, words[0]}, 50);
    abort_s[0] = 1'b1;
    @(negedge clk); #2;
    abort_s[0] = 1'b0;
    chk("t6_active", 0, {31'd0, active[0]}, 0);
    chk("t6_words",  0, {23'd0, words[0]}, 0);
    chk("t6_done",   0, {31'd0, done[0]}, 0);
    repeat (10) @(negedge clk);
    #2;
    chk("t6_late_ignored", 0, {31'd0, active[0]}, 0);
    do_start(0, 0);
    wait_idle(0, 5000, "t6_restart_idle");
    chk("t6_restart_done",  0, {31'd0, done[0]}, 1);
    chk("t6_restart_words", 0, {23'd0, words[0]}, 256);
    chk("t6_restart_first", 0, {16'd0, rd_data[0]}, 16'h0001);
    drain(0, 0, 256, 2000, "t6_drain");
  endtask

  initial begin
    start = '0; abort_s = '0; rd_pop = '0;
    for (int g = 0; g < N; g++) begin
      rmode[g] = 0; ridx[g] = 0; pidx[g] = 0; vidx[g] = 0; rpend[g] = 0; npulse[g] = 0;
    end
    repeat (2) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    #2;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Normal block
    do_start(0, 0);
    wait_idle(0, 5000, "t1_idle");
    chk("t1_done",   0, {31'd0, done[0]}, 1);
    chk("t1_error",  0, {30'd0, dut_err[0]}, 0);
    chk("t1_words",  0, {23'd0, words[0]}, 256);
    chk("t1_full",   0, {31'd0, full[0]}, 1);
    chk("t1_pulses", 0, npulse[0], 517);
    chk("t1_first",  0, {16'd0, rd_data[0]}, 16'h0001);
    drain(0, 0, 255, 2000, "t1_drain");
    chk("t1_last", 0, {16'd0, rd_data[0]}, 16'hFEFF);
    drain(0, 255, 1, 10, "t1_drain_last");

    // Token timeout
    repeat (5) @(negedge clk);
    do_start(0, 1);
    wait_idle(0, 9000, "t2_idle");
    chk("t2_error",  0, {30'd0, dut_err[0]}, 1);
    chk("t2_pulses", 0, npulse[0], HUNT_MAX);
    chk("t2_empty",  0, {31'd0, empty[0]}, 1);
    chk("t2_done",   0, {31'd0, done[0]}, 0);

    // Data-error token
    repeat (5) @(negedge clk);
    do_start(0, 2);
    wait_idle(0, 100, "t3_idle");
    chk("t3_error",  0, {30'd0, dut_err[0]}, 2);
    chk("t3_pulses", 0, npulse[0], 2);
    chk("t3_done",   0, {31'd0, done[0]}, 0);

    // Backpressure on the 16-word instance
    do_start(1, 0);
    repeat (300) @(negedge clk);
    #2;
    chk("t4_stall_pulses", 1, npulse[1], 35);
    chk("t4_stall_words",  1, {23'd0, words[1]}, 16);
    chk("t4_stall_full",   1, {31'd0, full[1]}, 1);
    chk("t4_stall_head",   1, {16'd0, rd_data[1]}, 16'h0001);
    rd_pop[1] = 1'b1;
    @(negedge clk); #2;
    rd_pop[1] = 1'b0;
    repeat (30) @(negedge clk);
    #2;
    chk("t4_pop_pulses", 1, npulse[1], 37);
    chk("t4_pop_words",  1, {23'd0, words[1]}, 16);
    drain(1, 1, 255, 6000, "t4_drain");
    wait_idle(1, 100, "t4_idle");
    chk("t4_done", 1, {31'd0, done[1]}, 1);

    // Simultaneous push/pop at one word, and pop while empty
    repeat (5) @(negedge clk);
    test_pop_push();

    // Reset in the middle of a block
    repeat (5) @(negedge clk);
    do_start(0, 0);
    repeat (60) @(negedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk); #2;
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Abort mid-block, then a clean restart
    test_abort();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog inst0 got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
